// File: rtl/mem_bus_arbiter.sv
// Shares one memory request port between fetch and load/store requesters, one transaction in flight.
// Latency: grant in IDLE, memory request from the next cycle, data_ok in the cycle mem_data_ok arrives (minimum 2 cycles).
// Backpressure: addr_ok is held low while a transaction is outstanding; mem_addr_ok stalls in REQ; mem_data_ok stalls in WAIT.
module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                resetn,
   // fetch side
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,
   // load/store side
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,
   // shared memory port
   output logic                mem_req,
   output logic                mem_wr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                last_data;   // 1: most recent grant went to the data side
   logic                owner_data;  // 1: in-flight transaction belongs to the data side
   logic                grant_inst;
   logic                grant_data;
   logic                lat_wr;
   logic [STRB_W-1:0]   lat_wstrb;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;

   // Round-robin grant, only evaluated in IDLE; contention goes to the side not served last.
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (resetn && state == IDLE) begin
         if (inst_req && data_req) begin
            grant_inst = last_data;
            grant_data = !last_data;
         end else begin
            grant_inst = inst_req;
            grant_data = data_req;
         end
      end
   end

   // Next state and handshake outputs; everything is forced low while reset is asserted.
   always_comb begin
      state_nxt    = state;
      mem_req      = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      case (state)
         IDLE: begin
            if (grant_inst || grant_data) state_nxt = REQ;
         end
         REQ: begin
            mem_req = resetn;
            if (mem_addr_ok) state_nxt = WAIT;
         end
         WAIT: begin
            if (mem_data_ok) begin
               state_nxt    = IDLE;
               inst_data_ok = resetn && !owner_data;
               data_data_ok = resetn && owner_data;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, arbitration history and latched request fields.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         last_data  <= 1'b1;
         owner_data <= 1'b0;
         lat_wr     <= 1'b0;
         lat_wstrb  <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else begin
         state <= state_nxt;
         if (grant_inst) begin
            last_data  <= 1'b0;
            owner_data <= 1'b0;
            lat_wr     <= 1'b0;
            lat_wstrb  <= '0;
            lat_addr   <= inst_addr;
            lat_wdata  <= '0;
         end else if (grant_data) begin
            last_data  <= 1'b1;
            owner_data <= 1'b1;
            lat_wr     <= data_wr;
            lat_wstrb  <= data_wstrb;
            lat_addr   <= data_addr;
            lat_wdata  <= data_wdata;
         end
      end
   end

   assign inst_addr_ok = grant_inst;
   assign data_addr_ok = grant_data;
   assign mem_wr       = lat_wr;
   assign mem_wstrb    = lat_wstrb;
   assign mem_addr     = lat_addr;
   assign mem_wdata    = lat_wdata;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;
   assign busy         = resetn && (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a transaction-level reference model.
// Latency: inputs driven at negedge, outputs checked 2 time units later, model advanced at posedge.
// Backpressure: memory handshakes are randomized to exercise stalls in both memory phases.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok;
   logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
   logic [3:0]  data_wstrb;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        mem_req, mem_wr, busy;
   logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   int n_vec = 0;
   int n_err = 0;

   // reference model: one transaction record plus whether memory has taken its address
   bit          m_active = 1'b0;
   bit          m_sent   = 1'b0;
   bit          m_owner_data = 1'b0;
   bit          m_last_data  = 1'b1;
   logic [31:0] m_addr, m_wdata;
   logic        m_wr;
   logic [3:0]  m_wstrb;
   bit          e_gi, e_gd;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
      inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = $urandom;
   endtask

   // compare every DUT output against the model for the current cycle
   task automatic eval();
      bit e_mreq, e_rsp;
      #2;
      e_gi = 0; e_gd = 0;
      if (resetn && !m_active) begin
         if (inst_req && data_req) begin
            e_gi = m_last_data;
            e_gd = !m_last_data;
         end else begin
            e_gi = inst_req;
            e_gd = data_req;
         end
      end
      e_mreq = resetn && m_active && !m_sent;
      e_rsp  = resetn && m_active && m_sent && mem_data_ok;
      chk("inst_addr_ok", inst_addr_ok, e_gi);
      chk("data_addr_ok", data_addr_ok, e_gd);
      chk("inst_data_ok", inst_data_ok, e_rsp && !m_owner_data);
      chk("data_data_ok", data_data_ok, e_rsp && m_owner_data);
      chk("mem_req", mem_req, e_mreq);
      chk("busy", busy, resetn && m_active);
      chk("inst_rdata", inst_rdata, mem_rdata);
      chk("data_rdata", data_rdata, mem_rdata);
      if (resetn && m_active)
         chk("mem_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, {m_wr, m_wstrb, m_addr, m_wdata});
   endtask

   // advance the model across the clock edge and return at the next negedge
   task automatic tick();
      @(posedge clk);
      if (!resetn) begin
         m_active = 0;
         m_last_data = 1;
      end else if (!m_active) begin
         if (e_gi || e_gd) begin
            m_active = 1;
            m_sent = 0;
            m_owner_data = e_gd;
            m_last_data = e_gd;
            m_addr  = e_gd ? data_addr  : inst_addr;
            m_wr    = e_gd ? data_wr    : 1'b0;
            m_wstrb = e_gd ? data_wstrb : 4'h0;
            m_wdata = e_gd ? data_wdata : 32'h0;
         end
      end else if (!m_sent) begin
         if (mem_addr_ok) m_sent = 1;
      end else if (mem_data_ok) begin
         m_active = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 0;
      eval(); tick();
      eval(); tick();
      resetn = 1;
   endtask

   initial begin
      int g;
      int n;
      resetn = 0;
      idle_inputs();
      @(negedge clk);

      // single fetch, zero-wait memory
      do_reset();
      inst_req = 1; inst_addr = 32'h1C000000;
      eval(); chk("r28_grant", inst_addr_ok, 1'b1); tick();
      inst_req = 0; mem_addr_ok = 1;
      eval(); chk("r28_mem_req", {mem_req, mem_wr}, 2'b10); chk("r28_mem_addr", mem_addr, 32'h1C000000); tick();
      mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h02800C0C;
      eval(); chk("r28_data_ok", inst_data_ok, 1'b1); chk("r28_rdata", inst_rdata, 32'h02800C0C); tick();
      mem_data_ok = 0;
      eval(); chk("r28_busy", busy, 1'b0); tick();

      // continuous contention: strict alternation starting with fetch
      do_reset();
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      g = 0;
      for (int i = 0; i < 24; i++) begin
         eval();
         chk("r29_onehot", inst_addr_ok & data_addr_ok, 1'b0);
         if (inst_addr_ok || data_addr_ok) begin
            chk("r29_order", data_addr_ok, g[0]);
            g++;
         end
         tick();
      end
      chk("r29_count", g, 8);

      // store with a stalled memory address phase
      do_reset();
      data_req = 1; data_wr = 1; data_addr = 32'h1C008000; data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF;
      eval(); chk("r30_grant", data_addr_ok, 1'b1); tick();
      n = 0;
      for (int i = 0; i < 3; i++) begin
         data_req = 0; data_addr = $urandom; data_wdata = $urandom; data_wstrb = 4'h0;
         mem_addr_ok = (i == 2);
         eval();
         chk("r30_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, {1'b1, 4'hF, 32'h1C008000, 32'hDEADBEEF});
         chk("r30_early_ok", data_data_ok, 1'b0);
         if (mem_req) n++;
         tick();
      end
      chk("r30_req_cycles", n, 3);
      mem_addr_ok = 0;
      eval(); chk("r30_wait", {mem_req, data_data_ok}, 2'b00); tick();
      mem_data_ok = 1;
      eval(); chk("r30_done", data_data_ok, 1'b1); tick();
      mem_data_ok = 0;

      // spurious responses in IDLE and REQ
      do_reset();
      mem_data_ok = 1;
      eval(); chk("r31_idle", {inst_data_ok, data_data_ok, busy}, 3'b000); tick();
      mem_data_ok = 0; inst_req = 1;
      eval(); tick();
      inst_req = 0; mem_data_ok = 1;
      eval(); chk("r31_req", {inst_data_ok, data_data_ok, mem_req}, 3'b001); tick();
      mem_data_ok = 0;
      eval(); chk("r31_stay", {mem_req, busy}, 2'b11); tick();
      mem_addr_ok = 1;
      eval(); tick();
      mem_addr_ok = 0; mem_data_ok = 1;
      eval(); chk("r31_finish", inst_data_ok, 1'b1); tick();
      mem_data_ok = 0;

      // reset while waiting for data
      do_reset();
      inst_req = 1;
      eval(); tick();
      inst_req = 0; mem_addr_ok = 1;
      eval(); tick();
      mem_addr_ok = 0; resetn = 0;
      eval(); chk("r32_in_reset", busy, 1'b0); tick();
      resetn = 1; mem_data_ok = 1;
      eval(); chk("r32_late_rsp", {inst_data_ok, data_data_ok, busy}, 3'b000); tick();
      mem_data_ok = 0; inst_req = 1; data_req = 1;
      eval(); chk("r32_first", {inst_addr_ok, data_addr_ok}, 2'b10); tick();

      // random traffic with random memory timing and occasional reset
      for (int i = 0; i < 3000; i++) begin
         resetn      = ($urandom_range(63) != 0);
         inst_req    = $urandom_range(1);
         data_req    = $urandom_range(1);
         data_wr     = $urandom_range(1);
         data_wstrb  = $urandom;
         inst_addr   = $urandom;
         data_addr   = $urandom;
         data_wdata  = $urandom;
         mem_addr_ok = $urandom_range(1);
         mem_data_ok = ($urandom_range(4) < 2);
         mem_rdata   = $urandom;
         eval();
         chk("rnd_onehot", inst_addr_ok & data_addr_ok, 1'b0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width; write strobe width SHALL be DATA_W/8.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 inst_req  in  1  fetch request; inst_addr  in  ADDR_W  fetch address.
REQ-006 inst_addr_ok  out  1  fetch request accepted; inst_data_ok  out  1  fetch data valid; inst_rdata  out  DATA_W  fetch data.
REQ-007 data_req  in  1  load/store request; data_wr  in  1  1=store; data_wstrb  in  DATA_W/8  byte enables; data_addr  in  ADDR_W; data_wdata  in  DATA_W.
REQ-008 data_addr_ok  out  1  load/store accepted; data_data_ok  out  1  load data valid / store done; data_rdata  out  DATA_W.
REQ-009 mem_req  out  1; mem_wr  out  1; mem_wstrb  out  DATA_W/8; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  shared memory request port.
REQ-010 mem_addr_ok  in  1  memory accepted request; mem_data_ok  in  1  memory response; mem_rdata  in  DATA_W.
REQ-011 busy  out  1  transaction outstanding (state != IDLE).

Function
REQ-012 The block SHALL share one memory port between fetch and data requesters, one outstanding transaction at a time.
REQ-013 FSM states SHALL be IDLE, REQ, WAIT.
REQ-014 IDLE: if any request is high, the winner's addr_ok SHALL be 1 that cycle, its fields (addr, wr, wstrb, wdata; inst uses wr=0, wstrb=0, wdata=0) SHALL be latched, owner latched, next state REQ.
REQ-015 Arbitration SHALL be round-robin: both requesting -> grant the requester not granted last; single requester -> grant it regardless.
REQ-016 last-grant register SHALL update only on grant; reset value "data", so first simultaneous request goes to inst.
REQ-017 At most one addr_ok SHALL be high per cycle; addr_ok SHALL be 0 in REQ and WAIT.
REQ-018 REQ: mem_req=1 with latched fields held stable; on mem_addr_ok=1 next state WAIT, else stay.
REQ-019 WAIT: mem_req=0; on mem_data_ok=1, owner's data_ok SHALL be 1 the same cycle, next state IDLE; else stay.
REQ-020 inst_rdata and data_rdata SHALL both equal mem_rdata combinationally; only the owner's data_ok qualifies it.
REQ-021 mem_data_ok outside WAIT SHALL be ignored (no data_ok raised).
REQ-022 Minimum latency grant->data_ok SHALL be 2 cycles (grant T, mem_addr_ok T+1, mem_data_ok T+2); next grant no earlier than cycle after data_ok.
REQ-023 A request deasserted after grant SHALL not affect the in-flight transaction.
REQ-024 mem_wr, mem_wstrb, mem_addr, mem_wdata SHALL hold latched values in REQ and WAIT.

Reset
REQ-025 resetn=0 at a posedge SHALL force IDLE, last-grant=data, latched fields=0, owner=inst.
REQ-026 During and after reset: mem_req, all addr_ok, all data_ok, busy SHALL be 0.
REQ-027 Reset mid-transaction SHALL abandon it; a late mem_data_ok after reset SHALL produce no data_ok.

Verification
REQ-028 inst_req only, addr 0x1C000000, mem_addr_ok at T+1, mem_data_ok at T+2 rdata 0x02800C0C -> inst_addr_ok at T, mem_addr=0x1C000000 mem_wr=0, inst_data_ok at T+2 with rdata 0x02800C0C, busy 0 at T+3.
REQ-029 inst_req and data_req both high from reset, continuously, zero-wait memory -> grants alternate inst, data, inst, data; never two addr_ok in one cycle.
REQ-030 data store addr 0x1C008000 wdata 0xDEADBEEF wstrb 0xF, mem_addr_ok delayed 3 cycles -> mem_req high 3 cycles, fields stable, data_data_ok only after mem_data_ok.
REQ-031 Spurious mem_data_ok while IDLE and in REQ -> no data_ok on either side, state unchanged.
REQ-032 resetn low in WAIT, mem_data_ok pulsed next cycle -> no data_ok, busy 0, next inst_req granted first.
